// File: rtl/conv_seq_pkg.sv
// Shared types for the convolution loop sequencer: FSM state encoding,
// the latched layer configuration, and the config legality check.
package conv_seq_pkg;

  localparam int CFG_W              = 16;
  localparam int MAX_KERNEL_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] width;
    logic [CFG_W-1:0] height;
    logic [CFG_W-1:0] cin;
    logic [CFG_W-1:0] cout;
    logic [CFG_W-1:0] kernel;
  } cfg_t;

  // A layer is runnable only if every dimension is non-zero and the kernel fits.
  function automatic logic cfg_is_valid(cfg_t c, int max_kernel);
    return !(c.width == '0 || c.height == '0 || c.cin == '0 ||
             c.cout == '0 || c.kernel == '0 || int'(c.kernel) > max_kernel);
  endfunction

endpackage

// File: rtl/loop_counter.sv
// One nested-loop counter: advances on enable and wraps to 0 after limit-1.
module loop_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n_in,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == limit - W'(1));

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Convolution loop sequencer: walks x, y, ch_in, ch_out, k_v, k_h and drives MAC,
// partial-sum memory and output handshake. Optional CONV_SEQ_PERF_CNT_EN adds perf counters.
module conv_loop_sequencer
  import conv_seq_pkg::*;
#(
  parameter int CNT_W              = CFG_W,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int MAX_KERNEL         = MAX_KERNEL_DEFAULT
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [CNT_W-1:0]              cfg_width,
  input  logic [CNT_W-1:0]              cfg_height,
  input  logic [CNT_W-1:0]              cfg_cin,
  input  logic [CNT_W-1:0]              cfg_cout,
  input  logic [CNT_W-1:0]              cfg_kernel,
  output logic                          running,
  output logic                          cfg_error,
  input  logic                          a_valid,
  input  logic                          b_valid,
  output logic                          a_ready,
  output logic                          b_ready,
  output logic                          mac_valid,
  output logic                          mac_accumulate_internal,
  output logic                          mac_accumulate_with_0,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [CNT_W-1:0]              output_x,
  output logic [CNT_W-1:0]              output_y,
  output logic [CNT_W-1:0]              output_ch,
  output logic                          done
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_cycles,
  output logic [31:0]                   perf_stalls
`endif
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] HOLD = ST_HOLD;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0] state, state_nxt;
  cfg_t       cfg_req, cfg_q;
  logic       cfg_ok, start_ok;
  logic       beat, out_blocked, last_issued, kernel_first;
  logic       en_kh, en_kv, en_co, en_ci, en_y, en_x;
  logic       kh_last, kv_last, co_last, ci_last, y_last, x_last;
  logic       layer_end, out_beat, out_accept;
  logic [CNT_W-1:0] x_cnt, y_cnt, ci_cnt, co_cnt, kv_cnt, kh_cnt;

  assign cfg_req.width  = CFG_W'(cfg_width);
  assign cfg_req.height = CFG_W'(cfg_height);
  assign cfg_req.cin    = CFG_W'(cfg_cin);
  assign cfg_req.cout   = CFG_W'(cfg_cout);
  assign cfg_req.kernel = CFG_W'(cfg_kernel);

  assign cfg_ok   = cfg_is_valid(cfg_req, MAX_KERNEL);
  assign start_ok = (state == IDLE) && start && cfg_ok;

  // Operands are refused once the last beat of the layer has been issued,
  // so surplus valid operands cannot start a phantom second pass.
  assign out_blocked = output_valid && !output_ready;
  assign a_ready     = (state == RUN) && !last_issued && !out_blocked;
  assign b_ready     = a_ready;
  assign beat        = a_valid && b_valid && a_ready && b_ready;
  assign out_accept  = output_valid && output_ready;

  assign en_kh     = beat;
  assign en_kv     = en_kh && kh_last;
  assign en_co     = en_kv && kv_last;
  assign en_ci     = en_co && co_last;
  assign en_y      = en_ci && ci_last;
  assign en_x      = en_y && y_last;
  assign layer_end = en_x && x_last;
  assign out_beat  = en_co && ci_last;

  loop_counter #(.W(CNT_W)) u_cnt_x (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_x),
    .limit(CNT_W'(cfg_q.width)), .count(x_cnt), .last(x_last));
  loop_counter #(.W(CNT_W)) u_cnt_y (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_y),
    .limit(CNT_W'(cfg_q.height)), .count(y_cnt), .last(y_last));
  loop_counter #(.W(CNT_W)) u_cnt_ci (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_ci),
    .limit(CNT_W'(cfg_q.cin)), .count(ci_cnt), .last(ci_last));
  loop_counter #(.W(CNT_W)) u_cnt_co (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_co),
    .limit(CNT_W'(cfg_q.cout)), .count(co_cnt), .last(co_last));
  loop_counter #(.W(CNT_W)) u_cnt_kv (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_kv),
    .limit(CNT_W'(cfg_q.kernel)), .count(kv_cnt), .last(kv_last));
  loop_counter #(.W(CNT_W)) u_cnt_kh (
    .clk(clk), .arst_n_in(arst_n_in), .clear(start_ok), .enable(en_kh),
    .limit(CNT_W'(cfg_q.kernel)), .count(kh_cnt), .last(kh_last));

  assign kernel_first            = (kv_cnt == '0) && (kh_cnt == '0);
  assign mac_valid               = beat;
  assign mac_accumulate_internal = beat && !kernel_first;
  assign mac_accumulate_with_0   = beat && kernel_first && (ci_cnt == '0);
  assign mem_re                  = beat && kernel_first && (ci_cnt != '0);
  assign mem_read_addr           = mem_re ? LOG2_OF_MEM_HEIGHT'(co_cnt) : '0;

  assign running = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN: begin
        if (out_accept && last_issued) state_nxt = DONE;
        else if (out_blocked)          state_nxt = HOLD;
      end
      HOLD: if (output_ready) state_nxt = last_issued ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state       <= IDLE;
      cfg_q       <= '0;
      cfg_error   <= 1'b0;
      last_issued <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_error <= (state == IDLE) && start && !cfg_ok;
      if (start_ok) cfg_q <= cfg_req;
      if (start_ok || state == DONE) last_issued <= 1'b0;
      else if (layer_end)            last_issued <= 1'b1;
    end
  end

  // A new final-kernel beat can only fire when no output is stuck, so loading
  // takes priority over the clear of an output accepted in the same cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      output_valid   <= 1'b0;
      output_x       <= '0;
      output_y       <= '0;
      output_ch      <= '0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
    end else begin
      mem_we <= en_co;
      if (en_co) mem_write_addr <= LOG2_OF_MEM_HEIGHT'(co_cnt);
      if (out_beat) begin
        output_valid <= 1'b1;
        output_x     <= x_cnt;
        output_y     <= y_cnt;
        output_ch    <= co_cnt;
      end else if (out_accept) begin
        output_valid <= 1'b0;
      end
    end
  end

`ifdef CONV_SEQ_PERF_CNT_EN
  logic active;
  assign active = (state == RUN) || (state == HOLD);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (active) begin
      if (perf_cycles != '1)         perf_cycles <= perf_cycles + 32'd1;
      if (!beat && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
